instruction_queue: RTL and testbench
====================================

# instruction_queue

Parametrised instruction register with a prefetch queue, sitting between instruction memory and the control unit. It buffers up to DEPTH fetched instruction words behind a valid/ready handshake. It presents the oldest word split into opcode, DA, AA and BA fields as registered outputs. The control unit retires that word with a single-cycle advance strobe, and a flush discards all buffered words on a branch.

## Interface
- FIELD_WIDTH, 4, width of each of the four instruction fields
- INSTR_WIDTH, 4*FIELD_WIDTH (16), instruction word width; must equal 4*FIELD_WIDTH
- DEPTH, 4, number of queue entries; power of two, >= 2
- CNT_WIDTH, $clog2(DEPTH+1), width of the occupancy count
- clk  input  1  single clock; all state updates on rising edge
- reset  input  1  asynchronous, active-high; clears all state immediately
- in_valid  input  1  in_instr holds a fetched instruction
- in_instr  input  INSTR_WIDTH  instruction word; fields MSB-first: opcode, DA, AA, BA
- in_ready  output  1  queue can accept a word this cycle
- advance  input  1  consumer retires the head instruction
- flush  input  1  discard all queued instructions
- out_valid  output  1  head fields are valid
- opcode  output  FIELD_WIDTH  in_instr[INSTR_WIDTH-1 -: FIELD_WIDTH] of head entry
- DA  output  FIELD_WIDTH  next field down (destination address)
- AA  output  FIELD_WIDTH  next field down (source A address)
- BA  output  FIELD_WIDTH  least-significant field (source B address)
- count  output  CNT_WIDTH  number of valid entries, 0..DEPTH
- underflow  output  1  sticky error: advance seen while empty

## Operation
- Storage: DEPTH x INSTR_WIDTH register array, write pointer wr_ptr, read pointer rd_ptr (log2(DEPTH) bits each), and count.
- Pointers wrap modulo DEPTH naturally.
- Write (push) fires when in_valid && in_ready: mem[wr_ptr] <= in_instr, wr_ptr++.
- Read (pop) fires when advance && out_valid: rd_ptr++.
- Count update: +1 on push only, -1 on pop only, unchanged on both or neither.
- in_ready = (count != DEPTH), combinational from count.
- When full, in_ready = 0, even if advance is high in the same cycle. A full queue does not pass a word through.
- out_valid = (count != 0).
- opcode/DA/AA/BA are slices of mem[rd_ptr] while out_valid = 1, and are forced to all zeros while out_valid = 0.
- advance while empty: no pop, pointers unchanged, underflow set to 1.
- Push and empty-advance in the same cycle: push happens and underflow is set. The new word is not popped.
- flush: rd_ptr, wr_ptr and count go to 0. Flush wins over push and pop in the same cycle, so the incoming word is dropped.
- flush clears underflow. Memory contents need not be cleared.
- reset: pointers, count and underflow go to 0, so out_valid = 0, all fields = 0, in_ready = 1. Storage contents are don't-care.
- Reset asserted mid-operation discards all entries with no partial update.
- The first edge after reset deasserts behaves as a normal cycle.

## Timing
- Push-to-output latency is 1 cycle: a word pushed at edge k into an empty queue shows on opcode/DA/AA/BA with out_valid = 1 after edge k.
- No combinational path from in_instr or in_valid to any output.
- Pop takes effect at the edge: the next entry (or zeros if now empty) appears after that edge.
- Consumers sample fields in the cycle they assert advance.
- Sustained throughput is one push and one pop per cycle whenever 0 < count < DEPTH.
- in_ready falls in the cycle after the push that fills the queue, and rises in the cycle after the pop from full.
- Flush takes 1 cycle: after the flush edge, out_valid = 0 and in_ready = 1. A push in the following cycle is accepted normally.
- underflow rises in the cycle after the offending edge and holds until flush or reset.

## Test plan
- Reset, then push 0x1234 with DEPTH=4 -> after 1 edge: out_valid=1, opcode=1, DA=2, AA=3, BA=4, count=1; all outputs 0 and in_ready=1 during reset.
- Push 0xA001, 0xA002, 0xA003, 0xA004 with advance=0 -> count=4, in_ready=0; push 0xA005 with in_valid=1 is ignored. Then advance for 4 cycles -> BA reads 1, 2, 3, 4; count=0.
- Fill to 2 entries, then push and advance every cycle for 10 cycles across the pointer wrap -> count stays 2 and words emerge in order with no loss or duplication.
- With 3 entries, assert flush and in_valid (0xBEEF) together -> count=0, out_valid=0, fields 0. Push 0x5678 next cycle -> opcode=5.
- Advance on an empty queue -> underflow=1, count=0. Push 0x1111 -> out_valid=1, underflow still 1. Flush -> underflow=0.
- Assert reset asynchronously mid-cycle with 2 entries queued -> count, out_valid and fields go to 0 before the next clk edge.

Source files
------------

// File: rtl/instruction_queue.sv
// instruction_queue: prefetch FIFO between instruction memory and the
// control unit. The oldest buffered word is presented already split into
// opcode / DA / AA / BA fields; the control unit retires it with advance,
// and flush discards everything on a taken branch.
//
// Handshake semantics:
//   input side  - a word transfers on a rising edge where in_valid && in_ready
//                 (and no flush); in_ready depends only on count, so a full
//                 queue refuses input even while the head is being retired.
//   output side - the head word retires on a rising edge where
//                 advance && out_valid; the fields are valid for sampling
//                 whenever out_valid is high. advance with out_valid low is
//                 an error that sets the sticky underflow flag.
module instruction_queue #(
    parameter int FIELD_WIDTH = 4,
    parameter int INSTR_WIDTH = 4 * FIELD_WIDTH,
    parameter int DEPTH       = 4,
    parameter int CNT_WIDTH   = $clog2(DEPTH + 1)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    input  logic [INSTR_WIDTH-1:0] in_instr,
    output logic                   in_ready,
    input  logic                   advance,
    input  logic                   flush,
    output logic                   out_valid,
    output logic [FIELD_WIDTH-1:0] opcode,
    output logic [FIELD_WIDTH-1:0] DA,
    output logic [FIELD_WIDTH-1:0] AA,
    output logic [FIELD_WIDTH-1:0] BA,
    output logic [CNT_WIDTH-1:0]   count,
    output logic                   underflow
);

    localparam int PTR_WIDTH = $clog2(DEPTH);
    localparam logic [CNT_WIDTH-1:0] FULL_COUNT = CNT_WIDTH'(DEPTH);

    logic [INSTR_WIDTH-1:0] mem [DEPTH];
    logic [PTR_WIDTH-1:0]   wr_ptr;
    logic [PTR_WIDTH-1:0]   rd_ptr;
    logic [INSTR_WIDTH-1:0] head;
    logic                   push;
    logic                   pop;

    // Handshake decode; status flags come only from registered count, so
    // nothing on the input side reaches an output combinationally.
    always_comb begin
        in_ready  = (count != FULL_COUNT);
        out_valid = (count != '0);
        push      = in_valid && in_ready;
        pop       = advance && out_valid;
    end

    // Head word split into fields, forced to zero while the queue is empty.
    always_comb begin
        head   = mem[rd_ptr];
        opcode = '0;
        DA     = '0;
        AA     = '0;
        BA     = '0;
        if (out_valid) begin
            opcode = head[INSTR_WIDTH-1 -: FIELD_WIDTH];
            DA     = head[INSTR_WIDTH-1-FIELD_WIDTH -: FIELD_WIDTH];
            AA     = head[INSTR_WIDTH-1-2*FIELD_WIDTH -: FIELD_WIDTH];
            BA     = head[FIELD_WIDTH-1:0];
        end
    end

    // Storage write; contents are never cleared, the pointers define validity.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wr_ptr] <= in_instr;
        end
    end

    // Pointers, occupancy and sticky underflow; flush overrides push and pop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            underflow <= 1'b0;
        end else if (flush) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            underflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_WIDTH'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_WIDTH'(1);
            end
            if (push && !pop) begin
                count <= count + CNT_WIDTH'(1);
            end else if (pop && !push) begin
                count <= count - CNT_WIDTH'(1);
            end
            if (advance && !out_valid) begin
                underflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_instruction_queue.sv
// Bench for instruction_queue: directed vectors, expected head words queued
// by the driver and compared by an independent monitor on every retirement.
module tb_instruction_queue;

    localparam int FW = 4;
    localparam int IW = 16;
    localparam int DP = 4;
    localparam int CW = 3;

    logic          clk;
    logic          reset;
    logic          in_valid;
    logic [IW-1:0] in_instr;
    logic          in_ready;
    logic          advance;
    logic          flush;
    logic          out_valid;
    logic [FW-1:0] opcode;
    logic [FW-1:0] DA;
    logic [FW-1:0] AA;
    logic [FW-1:0] BA;
    logic [CW-1:0] count;
    logic          underflow;

    logic [IW-1:0] exp_q[$];
    int            checks = 0;
    int            errors = 0;

    instruction_queue #(
        .FIELD_WIDTH(FW),
        .INSTR_WIDTH(IW),
        .DEPTH(DP),
        .CNT_WIDTH(CW)
    ) dut (
        .clk(clk),
        .reset(reset),
        .in_valid(in_valid),
        .in_instr(in_instr),
        .in_ready(in_ready),
        .advance(advance),
        .flush(flush),
        .out_valid(out_valid),
        .opcode(opcode),
        .DA(DA),
        .AA(AA),
        .BA(BA),
        .count(count),
        .underflow(underflow)
    );

    // Clock and watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    // Monitor: on every retirement the presented word must be the oldest expected one
    always @(negedge clk) begin
        if (!reset && advance && out_valid) begin
            checks = checks + 1;
            if (exp_q.size() == 0) begin
                errors = errors + 1;
                $display("FAIL head_word: actual %h required <none queued>", {opcode, DA, AA, BA});
            end else begin
                logic [IW-1:0] e;
                e = exp_q.pop_front();
                if ({opcode, DA, AA, BA} !== e) begin
                    errors = errors + 1;
                    $display("FAIL head_word: actual %h required %h", {opcode, DA, AA, BA}, e);
                end
            end
        end
    end

    // Driver helpers: inputs change 2 time units after each rising edge
    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks = checks + 1;
        if (act !== req) begin
            errors = errors + 1;
            $display("FAIL %s: actual %0h required %0h", name, act, req);
        end
    endtask

    task automatic push_word(input logic [IW-1:0] w);
        in_valid = 1'b1;
        in_instr = w;
        exp_q.push_back(w);
        cyc();
        in_valid = 1'b0;
    endtask

    task automatic pop_words(input int n);
        advance = 1'b1;
        repeat (n) cyc();
        advance = 1'b0;
    endtask

    initial begin
        reset    = 1'b1;
        in_valid = 1'b0;
        in_instr = '0;
        advance  = 1'b0;
        flush    = 1'b0;
        repeat (2) cyc();

        // Reset state
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_fields", 32'({opcode, DA, AA, BA}), 0);
        chk("rst_count", 32'(count), 0);
        chk("rst_in_ready", 32'(in_ready), 1);
        chk("rst_underflow", 32'(underflow), 0);
        reset = 1'b0;

        // Single push: one-cycle latency into the field outputs
        push_word(16'h1234);
        chk("t1_out_valid", 32'(out_valid), 1);
        chk("t1_opcode", 32'(opcode), 1);
        chk("t1_DA", 32'(DA), 2);
        chk("t1_AA", 32'(AA), 3);
        chk("t1_BA", 32'(BA), 4);
        chk("t1_count", 32'(count), 1);
        pop_words(1);
        chk("t1_drained", 32'(count), 0);

        // Fill to DEPTH; extra word refused even while the head retires
        push_word(16'hA001);
        push_word(16'hA002);
        push_word(16'hA003);
        push_word(16'hA004);
        chk("t2_full_count", 32'(count), 4);
        chk("t2_full_ready", 32'(in_ready), 0);
        in_valid = 1'b1;
        in_instr = 16'hA005;
        cyc();
        chk("t2_ignored_count", 32'(count), 4);
        advance = 1'b1;
        cyc();
        in_valid = 1'b0;
        chk("t2_pop_full_count", 32'(count), 3);
        chk("t2_ready_after_pop", 32'(in_ready), 1);
        cyc();
        cyc();
        cyc();
        advance = 1'b0;
        chk("t2_empty_count", 32'(count), 0);
        chk("t2_empty_valid", 32'(out_valid), 0);
        chk("t2_empty_ready", 32'(in_ready), 1);

        // Steady streaming across pointer wrap at occupancy 2
        push_word(16'hB000);
        push_word(16'hB001);
        for (int i = 2; i < 12; i++) begin
            in_valid = 1'b1;
            advance  = 1'b1;
            in_instr = 16'hB000 + 16'(i);
            exp_q.push_back(in_instr);
            cyc();
            chk($sformatf("t3_stream_count_%0d", i), 32'(count), 2);
        end
        in_valid = 1'b0;
        pop_words(2);
        chk("t3_drained", 32'(count), 0);

        // Flush wins over a simultaneous push
        push_word(16'hC001);
        push_word(16'hC002);
        push_word(16'hC003);
        chk("t4_pre_count", 32'(count), 3);
        flush    = 1'b1;
        in_valid = 1'b1;
        in_instr = 16'hBEEF;
        cyc();
        flush    = 1'b0;
        in_valid = 1'b0;
        exp_q.delete();
        chk("t4_flush_count", 32'(count), 0);
        chk("t4_flush_valid", 32'(out_valid), 0);
        chk("t4_flush_fields", 32'({opcode, DA, AA, BA}), 0);
        chk("t4_flush_ready", 32'(in_ready), 1);
        push_word(16'h5678);
        chk("t4_after_opcode", 32'(opcode), 5);
        chk("t4_after_count", 32'(count), 1);
        pop_words(1);

        // Underflow: empty advance, then push together with empty advance
        advance = 1'b1;
        cyc();
        chk("t5_underflow", 32'(underflow), 1);
        chk("t5_count", 32'(count), 0);
        in_valid = 1'b1;
        in_instr = 16'h1111;
        exp_q.push_back(16'h1111);
        cyc();
        in_valid = 1'b0;
        advance  = 1'b0;
        chk("t5_push_valid", 32'(out_valid), 1);
        chk("t5_push_count", 32'(count), 1);
        chk("t5_push_opcode", 32'(opcode), 1);
        chk("t5_sticky", 32'(underflow), 1);
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        exp_q.delete();
        chk("t5_flush_clear", 32'(underflow), 0);
        chk("t5_flush_count", 32'(count), 0);

        // Asynchronous reset mid-cycle with entries queued
        push_word(16'hD001);
        push_word(16'hD002);
        chk("t6_pre_count", 32'(count), 2);
        #1;
        reset = 1'b1;
        #1;
        exp_q.delete();
        chk("t6_async_count", 32'(count), 0);
        chk("t6_async_valid", 32'(out_valid), 0);
        chk("t6_async_fields", 32'({opcode, DA, AA, BA}), 0);
        chk("t6_async_ready", 32'(in_ready), 1);
        cyc();
        reset = 1'b0;
        push_word(16'hE0E0);
        chk("t6_post_count", 32'(count), 1);
        chk("t6_post_opcode", 32'(opcode), 14);
        pop_words(1);
        chk("t6_post_drained", 32'(count), 0);

        // Every expected word must have been retired
        chk("final_exp_q_empty", 32'(exp_q.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
